// File: rtl/dop_pkg.sv
// Shared constants and types for the DoP-to-native-DSD serializer.
// Markers, the silence pattern, word-slot indices, FSM states and the marker-tracking rule.
package dop_pkg;

    localparam logic [7:0] DOP_MARKER_A = 8'h05;
    localparam logic [7:0] DOP_MARKER_B = 8'hFA;
    localparam logic [7:0] DSD_SILENCE  = 8'h69;

    localparam int WORD_L_LO = 0;
    localparam int WORD_L_HI = 1;
    localparam int WORD_R_LO = 2;
    localparam int WORD_R_HI = 3;

    localparam logic [3:0] LAST_BIT = 4'd15;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Marker expected for the next frame.
    // After a valid frame it alternates. After an invalid frame it resyncs to the left marker when it can.
    function automatic logic [7:0] next_marker(input logic       valid,
                                               input logic [7:0] l_mk,
                                               input logic [7:0] exp_mk);
        logic [7:0] nxt;
        nxt = exp_mk;
        if (valid) begin
            nxt = (exp_mk == DOP_MARKER_A) ? DOP_MARKER_B : DOP_MARKER_A;
        end else if (l_mk == DOP_MARKER_A) begin
            nxt = DOP_MARKER_B;
        end else if (l_mk == DOP_MARKER_B) begin
            nxt = DOP_MARKER_A;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dsd_piso.sv
// 16-bit parallel-load, MSB-first shift register with a registered serial output.
// On a load, the MSB appears on sout straight away and the remaining bits queue behind it.
module dsd_piso #(
    parameter logic [15:0] RESET_WORD = 16'h6969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic        clr,
    input  logic [15:0] din,
    output logic        sout
);

    logic [15:0] shreg_q, shreg_d;
    logic        sout_q, sout_d;

    always_comb begin
        shreg_d = shreg_q;
        sout_d  = sout_q;
        if (clr) begin
            sout_d = 1'b0;
        end else if (load) begin
            sout_d  = din[15];
            shreg_d = {din[14:0], 1'b0};
        end else if (shift) begin
            sout_d  = shreg_q[15];
            shreg_d = {shreg_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= RESET_WORD;
            sout_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
        end
    end

    assign sout = sout_q;

endmodule

// File: rtl/dsd_master.sv
// DoP-to-native-DSD serializer clocked by the DSD bit clock.
// Each frame it fetches four words, checks the DoP markers and shifts out 16 bits per channel.
module dsd_master
    import dop_pkg::*;
#(
    parameter logic [7:0] SILENCE_BYTE = DSD_SILENCE,
    parameter bit         CHECK_MARKER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_n,
    input  logic        stop_n,
    output logic        data_req_out,
    input  logic [15:0] data_in,
    output logic [1:0]  sd_out,
    output logic        sck_out
);

    localparam logic [15:0] SILENCE_FRAME = {SILENCE_BYTE, SILENCE_BYTE};

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        req_q, req_d;
    logic        run_q, run_d;
    logic        stop_pending_q, stop_pending_d;
    logic [7:0]  exp_mk_q, exp_mk_d;

    // High bytes of all four words are L_b, L_mk, R_b, R_mk.
    // Low bytes are kept only for the odd words: L_a and R_a.
    logic [7:0]  hi_byte_q [4];
    logic [7:0]  hi_byte_d [4];
    logic [7:0]  lo_byte_q [2];
    logic [7:0]  lo_byte_d [2];

    logic [3:0]  next_cnt;
    logic        stop_now;
    logic        capture;
    logic        frame_valid;
    logic        load_silence;
    logic        piso_load, piso_shift, piso_clr;
    logic [15:0] l_din, r_din;
    logic        l_sout, r_sout;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        req_d          = 1'b0;
        run_d          = run_q;
        stop_pending_d = stop_pending_q;
        exp_mk_d       = exp_mk_q;
        capture        = 1'b0;
        load_silence   = 1'b0;
        piso_load      = 1'b0;
        piso_shift     = 1'b0;
        piso_clr       = 1'b0;

        next_cnt    = bit_cnt_q + 4'd1;
        stop_now    = stop_pending_q | ~stop_n;
        frame_valid = !CHECK_MARKER ||
                      ((hi_byte_q[WORD_L_HI] == exp_mk_q) && (hi_byte_q[WORD_R_HI] == exp_mk_q));

        case (state_q)
            IDLE: begin
                piso_clr = 1'b1;
                if (!start_n && stop_n) begin
                    // Prime the serializers with silence so the first frame plays idle pattern.
                    state_d        = RUN;
                    run_d          = 1'b1;
                    bit_cnt_d      = 4'd0;
                    req_d          = 1'b1;
                    stop_pending_d = 1'b0;
                    piso_clr       = 1'b0;
                    piso_load      = 1'b1;
                    load_silence   = 1'b1;
                end
            end
            RUN: begin
                capture        = (bit_cnt_q[1:0] == 2'd1);
                bit_cnt_d      = next_cnt;
                stop_pending_d = stop_now;
                req_d          = (next_cnt[1:0] == 2'd0) && !stop_now;
                if (bit_cnt_q == LAST_BIT) begin
                    if (stop_now) begin
                        state_d        = IDLE;
                        run_d          = 1'b0;
                        bit_cnt_d      = 4'd0;
                        stop_pending_d = 1'b0;
                        piso_clr       = 1'b1;
                    end else begin
                        piso_load    = 1'b1;
                        load_silence = !frame_valid;
                        exp_mk_d     = next_marker(frame_valid, hi_byte_q[WORD_L_HI], exp_mk_q);
                    end
                end else begin
                    piso_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hi
            assign hi_byte_d[gi] = (capture && bit_cnt_q[3:2] == 2'(gi)) ? data_in[15:8]
                                                                         : hi_byte_q[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_lo
            assign lo_byte_d[gi] = (capture && bit_cnt_q[3:2] == 2'(2 * gi + 1)) ? data_in[7:0]
                                                                                 : lo_byte_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 4'd0;
            req_q          <= 1'b0;
            run_q          <= 1'b0;
            stop_pending_q <= 1'b0;
            exp_mk_q       <= DOP_MARKER_A;
            for (int i = 0; i < 4; i++) hi_byte_q[i] <= 8'h00;
            for (int i = 0; i < 2; i++) lo_byte_q[i] <= 8'h00;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            req_q          <= req_d;
            run_q          <= run_d;
            stop_pending_q <= stop_pending_d;
            exp_mk_q       <= exp_mk_d;
            for (int i = 0; i < 4; i++) hi_byte_q[i] <= hi_byte_d[i];
            for (int i = 0; i < 2; i++) lo_byte_q[i] <= lo_byte_d[i];
        end
    end

    // Channel frame is {a, b}, where a is the older byte and is sent first.
    assign l_din = load_silence ? SILENCE_FRAME : {lo_byte_q[0], hi_byte_q[WORD_L_LO]};
    assign r_din = load_silence ? SILENCE_FRAME : {lo_byte_q[1], hi_byte_q[WORD_R_LO]};

    dsd_piso #(.RESET_WORD(SILENCE_FRAME)) u_piso_l (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .clr   (piso_clr),
        .din   (l_din),
        .sout  (l_sout)
    );

    dsd_piso #(.RESET_WORD(SILENCE_FRAME)) u_piso_r (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .clr   (piso_clr),
        .din   (r_din),
        .sout  (r_sout)
    );

    assign data_req_out = req_q;
    assign sd_out       = {r_sout, l_sout};
    // run_q only changes on the rising edge, while ~clk is low, so the gated clock cannot glitch.
    assign sck_out      = run_q & ~clk;

endmodule

// File: tb/tb_dsd_master.sv
// Self-checking bench for dsd_master: a word-level frame model predicts each channel frame.
// Predictions come from the DoP marker rules, and the bench checks the serial output against them.
module tb_dsd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_n;
    logic        stop_n;
    logic        data_req_out;
    logic [15:0] data_in;
    logic [1:0]  sd_out;
    logic        sck_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mk;
    logic [7:0]  alt_mk;
    logic [15:0] prev_l, prev_r;
    int          frame_no = 0;

    dsd_master dut (
        .clk          (clk),
        .rst          (rst),
        .start_n      (start_n),
        .stop_n       (stop_n),
        .data_req_out (data_req_out),
        .data_in      (data_in),
        .sd_out       (sd_out),
        .sck_out      (sck_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected channel frames for one fetched frame, from the marker rules.
    function automatic void model_frame(input logic [15:0] w0, input logic [15:0] w1,
                                        input logic [15:0] w2, input logic [15:0] w3,
                                        output logic [15:0] l, output logic [15:0] r);
        if (w1[15:8] == model_mk && w3[15:8] == model_mk) begin
            l = {w1[7:0], w0[15:8]};
            r = {w3[7:0], w2[15:8]};
            model_mk = (model_mk == 8'h05) ? 8'hFA : 8'h05;
        end else begin
            l = 16'h6969;
            r = 16'h6969;
            if (w1[15:8] == 8'h05)      model_mk = 8'hFA;
            else if (w1[15:8] == 8'hFA) model_mk = 8'h05;
        end
    endfunction

    // Play one 16-cycle frame starting at the next negedge.
    // Collect the serial bits, feed a word after each request and optionally request a stop.
    task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3, input int stop_at,
                             output logic [15:0] l, output logic [15:0] r,
                             output logic [15:0] reqm, output logic [15:0] sckm);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        l = '0; r = '0; reqm = '0; sckm = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            l[15-k]  = sd_out[0];
            r[15-k]  = sd_out[1];
            reqm[k]  = data_req_out;
            sckm[k]  = sck_out;
            if (data_req_out) data_in = w[k/4];
            if (k == stop_at) begin
                start_n = 1'b1;
                stop_n  = 1'b0;
            end
        end
    endtask

    task automatic do_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] l, r, reqm, sckm;
        run_frame(w0, w1, w2, w3, -1, l, r, reqm, sckm);
        frame_no++;
        $display("frame %0d: L=%h R=%h (model L=%h R=%h) req=%h sck=%h",
                 frame_no, l, r, prev_l, prev_r, reqm, sckm);
        check_eq("frame_l", {16'h0, l}, {16'h0, prev_l});
        check_eq("frame_r", {16'h0, r}, {16'h0, prev_r});
        check_eq("req_pattern", {16'h0, reqm}, 32'h1111);
        check_eq("sck_pattern", {16'h0, sckm}, 32'hFFFF);
        model_frame(w0, w1, w2, w3, prev_l, prev_r);
    endtask

    task automatic rand_frame(input logic [7:0] l_mk, input logic [7:0] r_mk);
        logic [15:0] w0, w1, w2, w3;
        w0 = 16'($urandom_range(65535));
        w1 = {l_mk, 8'($urandom_range(255))};
        w2 = 16'($urandom_range(65535));
        w3 = {r_mk, 8'($urandom_range(255))};
        do_frame(w0, w1, w2, w3);
    endtask

    task automatic idle_check(input int n, input string tag);
        logic       req_any = 1'b0;
        logic       sck_any = 1'b0;
        logic [1:0] sd_any  = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_any |= data_req_out;
            sck_any |= sck_out;
            sd_any  |= sd_out;
        end
        $display("idle %s: %0d cycles req=%b sd=%b sck=%b", tag, n, req_any, sd_any, sck_any);
        check_eq({tag, "_req"}, {31'h0, req_any}, 32'h0);
        check_eq({tag, "_sd"},  {30'h0, sd_any},  32'h0);
        check_eq({tag, "_sck"}, {31'h0, sck_any}, 32'h0);
    endtask

    initial begin
        logic [15:0] l, r, reqm, sckm;
        rst      = 1'b1;
        start_n  = 1'b1;
        stop_n   = 1'b1;
        data_in  = 16'h0;
        model_mk = 8'h05;
        repeat (3) @(negedge clk);
        check_eq("rst_req", {31'h0, data_req_out}, 32'h0);
        check_eq("rst_sd",  {30'h0, sd_out},       32'h0);
        check_eq("rst_sck", {31'h0, sck_out},      32'h0);
        rst = 1'b0;

        idle_check(100, "idle_after_reset");

        // Start with the directed example.
        start_n = 1'b0;
        prev_l  = 16'h6969;
        prev_r  = 16'h6969;
        do_frame(16'hA500, 16'h05C3, 16'h3C00, 16'h055A);

        // Ten random frames with correctly alternating markers.
        alt_mk = 8'hFA;
        for (int i = 0; i < 10; i++) begin
            rand_frame(alt_mk, alt_mk);
            alt_mk = ~alt_mk;
        end

        // One corrupted left marker, then the normal alternation resumes.
        rand_frame(8'h06, alt_mk);
        alt_mk = ~alt_mk;
        for (int i = 0; i < 5; i++) begin
            rand_frame(alt_mk, alt_mk);
            alt_mk = ~alt_mk;
        end

        // Stop in the middle of a frame.
        run_frame(16'h1234, {alt_mk, 8'h56}, 16'h789A, {alt_mk, 8'hBC}, 6, l, r, reqm, sckm);
        $display("stop frame: L=%h R=%h req=%h sck=%h", l, r, reqm, sckm);
        check_eq("stop_frame_l", {16'h0, l}, {16'h0, prev_l});
        check_eq("stop_frame_r", {16'h0, r}, {16'h0, prev_r});
        check_eq("stop_req", {16'h0, reqm}, 32'h0011);
        check_eq("stop_sck", {16'h0, sckm}, 32'hFFFF);
        idle_check(20, "after_stop");

        // Start and stop asserted together: stop wins.
        start_n = 1'b0;
        idle_check(12, "start_and_stop");

        // Releasing stop with start still held low restarts streaming.
        stop_n = 1'b1;
        prev_l = 16'h6969;
        prev_r = 16'h6969;
        alt_mk = model_mk;
        for (int i = 0; i < 3; i++) begin
            rand_frame(alt_mk, alt_mk);
            alt_mk = ~alt_mk;
        end

        // Reset in the middle of a frame.
        repeat (5) @(negedge clk);
        start_n = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        $display("mid-run reset: req=%b sd=%b sck=%b", data_req_out, sd_out, sck_out);
        check_eq("midrst_req", {31'h0, data_req_out}, 32'h0);
        check_eq("midrst_sd",  {30'h0, sd_out},       32'h0);
        check_eq("midrst_sck", {31'h0, sck_out},      32'h0);
        rst = 1'b0;
        idle_check(10, "after_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
